// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel clock-enable, sync/blank decode, line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the registered 16-bit frame_count output.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int COUNT_W   = 11,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               restart,
   output logic               pix_en,
   output logic               hsync,
   output logic               vsync,
   output logic               hblank,
   output logic               vblank,
   output logic               active_video,
   output logic               line_start,
   output logic               frame_start,
   output logic [COUNT_W-1:0] h_count,
   output logic [COUNT_W-1:0] v_count
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]        frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW1     = COUNT_W + 1;

   if (CLK_DIV < 1 || CLK_DIV > 256) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be in 1..256");
   end
   if (H_TOTAL > (1 << COUNT_W) || V_TOTAL > (1 << COUNT_W)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COUNT_W bits");
   end

   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
   // Decode bounds are one bit wider so a sync ending exactly at 2**COUNT_W still compares correctly.
   localparam logic [CW1-1:0] H_BLANK_START = CW1'(H_ACTIVE);
   localparam logic [CW1-1:0] HS_START      = CW1'(H_ACTIVE + H_FP);
   localparam logic [CW1-1:0] HS_END        = CW1'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW1-1:0] V_BLANK_START = CW1'(V_ACTIVE);
   localparam logic [CW1-1:0] VS_START      = CW1'(V_ACTIVE + V_FP);
   localparam logic [CW1-1:0] VS_END        = CW1'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0]   div_cnt;
   logic [COUNT_W-1:0] h_next;
   logic [COUNT_W-1:0] v_next;
   logic [CW1-1:0]     h_ext;
   logic [CW1-1:0]     v_ext;
   logic               clear;
   logic               h_wrap;
   logic               v_wrap;

   assign clear       = reset | restart;
   assign pix_en      = (div_cnt == DIV_LAST);
   assign h_wrap      = pix_en && (h_count == H_LAST);
   assign v_wrap      = h_wrap && (v_count == V_LAST);
   assign line_start  = pix_en && (h_count == '0);
   assign frame_start = line_start && (v_count == '0);

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      h_next = h_count;
      v_next = v_count;
      if (pix_en) begin
         if (h_wrap) begin
            h_next = '0;
            v_next = v_wrap ? '0 : v_count + 1'b1;
         end else begin
            h_next = h_count + 1'b1;
         end
      end
   end

   assign h_ext = {1'b0, h_next};
   assign v_ext = {1'b0, v_next};

   // Sync and blank flags are decoded from the next counts so they move on the same edge as the counts.
   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (clear) begin
         div_cnt      <= '0;
         h_count      <= '0;
         v_count      <= '0;
         hsync        <= ~HSYNC_POL;
         vsync        <= ~VSYNC_POL;
         hblank       <= 1'b0;
         vblank       <= 1'b0;
         active_video <= 1'b1;
      end else begin
         div_cnt      <= pix_en ? '0 : div_cnt + 1'b1;
         h_count      <= h_next;
         v_count      <= v_next;
         hsync        <= (h_ext >= HS_START && h_ext < HS_END) ? HSYNC_POL : ~HSYNC_POL;
         vsync        <= (v_ext >= VS_START && v_ext < VS_END) ? VSYNC_POL : ~VSYNC_POL;
         hblank       <= (h_ext >= H_BLANK_START);
         vblank       <= (v_ext >= V_BLANK_START);
         active_video <= (h_ext < H_BLANK_START) && (v_ext < V_BLANK_START);
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         frame_count <= '0;
      end else if (v_wrap) begin
         frame_count <= frame_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations against an arithmetic raster model.
// The model derives every output from the number of clocks elapsed since the last reset/restart.
module tb_vga_timing_gen;

   typedef struct packed {
      logic        pix_en;
      logic        hsync;
      logic        vsync;
      logic        hblank;
      logic        vblank;
      logic        active_video;
      logic        line_start;
      logic        frame_start;
      logic [10:0] h;
      logic [10:0] v;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      int div, ha, hf, hs, hb, va, vf, vs, vb;
      bit hp, vp;
   } cfg_t;

   localparam obs_t RESET_BIG = '{pix_en: 1'b0, hsync: 1'b1, vsync: 1'b1, hblank: 1'b0, vblank: 1'b0,
                                  active_video: 1'b1, line_start: 1'b0, frame_start: 1'b0,
                                  h: 11'd0, v: 11'd0, fc: 16'd0};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  restart = '0;
   logic [2:0]  pe, hs, vs, hb, vb, av, ls, fs;
   logic [10:0] h0, v0, h2, v2;
   logic [4:0]  h1, v1;
   logic [15:0] fc0, fc1, fc2;
   obs_t        obs0, obs1, obs2;
   int          t [3];
   int          cyc;
   int          n_assert;
   int          n_fail;

   always #5 clk = ~clk;

   vga_timing_gen u_big (
      .clk(clk), .reset(reset), .restart(restart[0]), .pix_en(pe[0]), .hsync(hs[0]), .vsync(vs[0]),
      .hblank(hb[0]), .vblank(vb[0]), .active_video(av[0]), .line_start(ls[0]),
      .frame_start(fs[0]), .h_count(h0), .v_count(v0)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc0)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(3), .COUNT_W(5), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
   ) u_mid (
      .clk(clk), .reset(reset), .restart(restart[1]), .pix_en(pe[1]), .hsync(hs[1]), .vsync(vs[1]),
      .hblank(hb[1]), .vblank(vb[1]), .active_video(av[1]), .line_start(ls[1]),
      .frame_start(fs[1]), .h_count(h1), .v_count(v1)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc1)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_small (
      .clk(clk), .reset(reset), .restart(restart[2]), .pix_en(pe[2]), .hsync(hs[2]), .vsync(vs[2]),
      .hblank(hb[2]), .vblank(vb[2]), .active_video(av[2]), .line_start(ls[2]),
      .frame_start(fs[2]), .h_count(h2), .v_count(v2)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc2)
`endif
   );

`ifndef VGA_FRAME_CNT_EN
   assign fc0 = 16'd0;
   assign fc1 = 16'd0;
   assign fc2 = 16'd0;
`endif

   assign obs0 = {pe[0], hs[0], vs[0], hb[0], vb[0], av[0], ls[0], fs[0], h0, v0, fc0};
   assign obs1 = {pe[1], hs[1], vs[1], hb[1], vb[1], av[1], ls[1], fs[1], 6'd0, h1, 6'd0, v1, fc1};
   assign obs2 = {pe[2], hs[2], vs[2], hb[2], vb[2], av[2], ls[2], fs[2], h2, v2, fc2};

   function automatic obs_t get_obs(int k);
      case (k)
         0:       return obs0;
         1:       return obs1;
         default: return obs2;
      endcase
   endfunction

   function automatic cfg_t cfg_of(int k);
      cfg_t c;
      case (k)
         0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
         1:       c = '{3, 10, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b0};
         default: c = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
      endcase
      return c;
   endfunction

   // Raster position is simply (clocks / CLK_DIV) unrolled over the line and frame lengths.
   function automatic obs_t model(cfg_t c, int tt);
      obs_t o;
      int   htot, vtot, p, h, v;
      htot = c.ha + c.hf + c.hs + c.hb;
      vtot = c.va + c.vf + c.vs + c.vb;
      p    = tt / c.div;
      h    = p % htot;
      v    = (p / htot) % vtot;
      o    = '0;
      o.pix_en       = ((tt % c.div) == c.div - 1);
      o.h            = 11'(h);
      o.v            = 11'(v);
      o.hblank       = (h >= c.ha);
      o.vblank       = (v >= c.va);
      o.active_video = !o.hblank && !o.vblank;
      o.hsync        = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
      o.vsync        = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
      o.line_start   = o.pix_en && (h == 0);
      o.frame_start  = o.line_start && (v == 0);
`ifdef VGA_FRAME_CNT_EN
      o.fc           = 16'((p / (htot * vtot)) % 65536);
`endif
      return o;
   endfunction

   task automatic tick(input bit rst, input logic [2:0] rs);
      reset   = rst;
      restart = rs;
      @(posedge clk);
      for (int k = 0; k < 3; k++) t[k] = (rst || rs[k]) ? 0 : t[k] + 1;
      cyc++;
      @(negedge clk);
      reset   = 1'b0;
      restart = '0;
   endtask

   task automatic test_reset();
      int first_pe = 0;
      int n_pe     = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, '0);
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL reset_hold dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
      end
      for (int c = 1; c <= 8; c++) begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL reset_release dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
         if (pe[0]) begin
            n_pe++;
            if (first_pe == 0) first_pe = c;
         end
         tick(1'b0, '0);
      end
      n_assert++;
      if (first_pe !== 4) begin
         n_fail++;
         $display("FAIL first_pix_en got=%0d exp=4", first_pe);
      end
      n_assert++;
      if (n_pe !== 2) begin
         n_fail++;
         $display("FAIL pix_en_count_8clk got=%0d exp=2", n_pe);
      end
      n_assert++;
      if (h0 !== 11'd2) begin
         n_fail++;
         $display("FAIL h_after_8clk got=%0d exp=2", h0);
      end
   endtask

   task automatic test_line();
      int hs_min = 9999, hs_max = -1, hs_n = 0, hb_min = 9999, hb_n = 0, ls_n = 0;
      bit wrapped = 1'b0;
      logic [10:0] ph, pv;
      ph = h0;
      pv = v0;
      for (int i = 0; i < 3300; i++) begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL line dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
         if (pe[0] && v0 == 11'd0) begin
            if (!hs[0]) begin
               hs_n++;
               if (int'(h0) < hs_min) hs_min = int'(h0);
               if (int'(h0) > hs_max) hs_max = int'(h0);
            end
            if (hb[0]) begin
               hb_n++;
               if (int'(h0) < hb_min) hb_min = int'(h0);
            end
         end
         if (ls[0]) ls_n++;
         if (ph == 11'd799 && pv == 11'd0 && h0 == 11'd0 && v0 == 11'd1) wrapped = 1'b1;
         ph = h0;
         pv = v0;
         tick(1'b0, '0);
      end
      n_assert++;
      if (hs_min !== 656 || hs_max !== 751 || hs_n !== 96) begin
         n_fail++;
         $display("FAIL hsync_window got=%0d..%0d n=%0d exp=656..751 n=96", hs_min, hs_max, hs_n);
      end
      n_assert++;
      if (hb_min !== 640 || hb_n !== 160) begin
         n_fail++;
         $display("FAIL hblank_window got=%0d n=%0d exp=640 n=160", hb_min, hb_n);
      end
      n_assert++;
      if (ls_n !== 1) begin
         n_fail++;
         $display("FAIL line_start_count got=%0d exp=1", ls_n);
      end
      n_assert++;
      if (!wrapped) begin
         n_fail++;
         $display("FAIL h_wrap_799 got=0 exp=1");
      end
   endtask

   task automatic test_frame();
      int last_fs = -1, n_fs = 0;
      int hs2_min = 99, hs2_max = -1, vs2_min = 99, vs2_max = -1;
      int hs1_min = 99, hs1_max = -1, vs1_min = 99, vs1_max = -1, vb1_min = 99, vb1_max = -1;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL frame dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
         if (hs[2]) begin hs2_min = (int'(h2) < hs2_min) ? int'(h2) : hs2_min; hs2_max = (int'(h2) > hs2_max) ? int'(h2) : hs2_max; end
         if (vs[2]) begin vs2_min = (int'(v2) < vs2_min) ? int'(v2) : vs2_min; vs2_max = (int'(v2) > vs2_max) ? int'(v2) : vs2_max; end
         if (hs[1]) begin hs1_min = (int'(h1) < hs1_min) ? int'(h1) : hs1_min; hs1_max = (int'(h1) > hs1_max) ? int'(h1) : hs1_max; end
         if (!vs[1]) begin vs1_min = (int'(v1) < vs1_min) ? int'(v1) : vs1_min; vs1_max = (int'(v1) > vs1_max) ? int'(v1) : vs1_max; end
         if (vb[1]) begin vb1_min = (int'(v1) < vb1_min) ? int'(v1) : vb1_min; vb1_max = (int'(v1) > vb1_max) ? int'(v1) : vb1_max; end
         if (fs[2]) begin
            if (last_fs >= 0) begin
               n_assert++;
               if (cyc - last_fs !== 48) begin
                  n_fail++;
                  $display("FAIL small_frame_period got=%0d exp=48", cyc - last_fs);
               end
            end
            last_fs = cyc;
            n_fs++;
         end
         tick(1'b0, '0);
      end
      n_assert++;
      if (n_fs < 20) begin
         n_fail++;
         $display("FAIL small_frame_count got=%0d exp>=20", n_fs);
      end
      n_assert++;
      if (hs2_min !== 5 || hs2_max !== 6 || vs2_min !== 4 || vs2_max !== 4) begin
         n_fail++;
         $display("FAIL small_sync got=h%0d..%0d v%0d..%0d exp=h5..6 v4..4", hs2_min, hs2_max, vs2_min, vs2_max);
      end
      n_assert++;
      if (hs1_min !== 12 || hs1_max !== 14 || vs1_min !== 6 || vs1_max !== 7 || vb1_min !== 5 || vb1_max !== 8) begin
         n_fail++;
         $display("FAIL mid_sync got=h%0d..%0d vs%0d..%0d vb%0d..%0d exp=h12..14 vs6..7 vb5..8",
                  hs1_min, hs1_max, vs1_min, vs1_max, vb1_min, vb1_max);
      end
   endtask

   task automatic test_restart();
      int tk [2] = '{0, 1};
      int th [2] = '{300, 8};
      int tv [2] = '{1, 4};
      for (int j = 0; j < 2; j++) begin
         int   k = tk[j];
         bit   found = 1'b0;
         int   fs_clk = 0;
         cfg_t c = cfg_of(k);
         obs_t o;
         for (int i = 0; i < 5000 && !found; i++) begin
            for (int m = 0; m < 3; m++) begin
               n_assert++;
               if (get_obs(m) !== model(cfg_of(m), t[m])) begin
                  n_fail++;
                  $display("FAIL restart_seek dut%0d cyc=%0d got=%h exp=%h", m, cyc, get_obs(m), model(cfg_of(m), t[m]));
               end
            end
            o = get_obs(k);
            if (int'(o.h) == th[j] && int'(o.v) == tv[j] && o.pix_en) found = 1'b1;
            else tick(1'b0, '0);
         end
         n_assert++;
         if (!found) begin
            n_fail++;
            $display("FAIL restart_target_timeout dut%0d got=0 exp=1", k);
         end
         tick(1'b0, 3'(1 << k));
         o = get_obs(k);
         n_assert++;
         if (o.h !== 11'd0 || o.v !== 11'd0 || o.hsync !== !c.hp || o.vsync !== !c.vp || o.pix_en !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_state dut%0d got h=%0d v=%0d hs=%b vs=%b pe=%b exp h=0 v=0 hs=%b vs=%b pe=0",
                     k, o.h, o.v, o.hsync, o.vsync, o.pix_en, !c.hp, !c.vp);
         end
         for (int cc = 1; cc <= 300 && fs_clk == 0; cc++) begin
            n_assert++;
            if (get_obs(k) !== model(c, t[k])) begin
               n_fail++;
               $display("FAIL restart_run dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(c, t[k]));
            end
            if (get_obs(k).frame_start) fs_clk = cc;
            else tick(1'b0, '0);
         end
         n_assert++;
         if (fs_clk !== c.div) begin
            n_fail++;
            $display("FAIL restart_frame_start dut%0d got=%0d exp=%0d", k, fs_clk, c.div);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      int pe_clk = 0;
      tick(1'b1, 3'b111);
      n_assert++;
      if (obs0 !== RESET_BIG) begin
         n_fail++;
         $display("FAIL reset_and_restart got=%h exp=%h", obs0, RESET_BIG);
      end
      for (int i = 0; i < 4000 && !found; i++) begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL reset_mid_seek dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
         if (h0 == 11'd700) found = 1'b1;
         else tick(1'b0, '0);
      end
      n_assert++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_mid_timeout got=0 exp=1");
      end
      tick(1'b1, '0);
      n_assert++;
      if (obs0 !== RESET_BIG) begin
         n_fail++;
         $display("FAIL reset_at_h700 got=%h exp=%h", obs0, RESET_BIG);
      end
      for (int c = 1; c <= 20 && pe_clk == 0; c++) begin
         if (pe[0]) pe_clk = c;
         else tick(1'b0, '0);
      end
      n_assert++;
      if (pe_clk !== 4) begin
         n_fail++;
         $display("FAIL reset_mid_next_pix_en got=%0d exp=4", pe_clk);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 15000; i++) begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (get_obs(k) !== model(cfg_of(k), t[k])) begin
               n_fail++;
               $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", k, cyc, get_obs(k), model(cfg_of(k), t[k]));
            end
         end
         tick($urandom_range(499) == 0,
              {$urandom_range(149) == 0, $urandom_range(149) == 0, $urandom_range(149) == 0});
      end
   endtask

   initial begin
      cyc      = 0;
      n_assert = 0;
      n_fail   = 0;
      for (int k = 0; k < 3; k++) t[k] = 0;
      test_reset();
      test_line();
      test_frame();
      test_restart();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
